// File: rtl/avalon_pio_pulse.sv
// avalon_pio_pulse
//   Avalon-MM PIO slave for control flags. Output bits can be set as plain levels or
//   launched as self-clearing strobes of PULSE_CYCLES clocks. Input bits pass through a
//   2-flop synchroniser, and a per-bit edge capture raises a maskable level interrupt.
//   Reads are combinational with zero wait states and have no side effects.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous active-high reset
//   address    word address (0 DATA, 1 PULSE, 2 IN, 3 EDGE, 4 MASK, 5 SET, 6 CLR)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  write data; bits at and above WIDTH are ignored
//   readdata   combinational read data, zero-extended to 32 bits
//   in_port    asynchronous external inputs
//   out_port   registered outputs
//   irq        |(edge_cap & irq_mask)

module avalon_pio_pulse #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned PULSE_CYCLES = 16,
   parameter logic [31:0] RESET_VALUE  = 32'h0,
   parameter int unsigned EDGE_TYPE    = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam int unsigned CntW = 16;

   localparam logic [2:0] AddrData  = 3'd0;
   localparam logic [2:0] AddrPulse = 3'd1;
   localparam logic [2:0] AddrIn    = 3'd2;
   localparam logic [2:0] AddrEdge  = 3'd3;
   localparam logic [2:0] AddrMask  = 3'd4;
   localparam logic [2:0] AddrSet   = 3'd5;
   localparam logic [2:0] AddrClr   = 3'd6;

   localparam logic [WIDTH-1:0] OutReset = RESET_VALUE[WIDTH-1:0];
   localparam logic [CntW-1:0]  PulseLen = CntW'(PULSE_CYCLES);

   // Output side state
   logic [WIDTH-1:0] out_q, out_d;
   logic [WIDTH-1:0] armed_q, armed_d;   // bits owned by the running strobe
   logic [CntW-1:0]  cnt_q, cnt_d;       // cycles left until the strobe expires

   // Input side state
   logic [WIDTH-1:0] s1_q, s1_d;
   logic [WIDTH-1:0] s2_q, s2_d;
   logic [WIDTH-1:0] s3_q, s3_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;

   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] edge_cond;
   logic             unused_writedata;

   assign wr_en   = chipselect & ~write_n;
   assign wr_data = writedata[WIDTH-1:0];

   // Upper writedata bits are architecturally ignored when WIDTH < 32.
   assign unused_writedata = ^writedata;

   // Edge detection runs on the synchronised sample (s2) against its delayed copy (s3).
   always_comb begin
      edge_cond = '0;
      case (EDGE_TYPE)
         0:       edge_cond = s2_q & ~s3_q;
         1:       edge_cond = ~s2_q & s3_q;
         default: edge_cond = s2_q ^ s3_q;
      endcase
   end

   // Output register, strobe bookkeeping and pulse counter
   always_comb begin
      out_d   = out_q;
      armed_d = armed_q;
      cnt_d   = cnt_q;

      // Expiry is resolved first so that a write landing in the same cycle wins.
      if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CntW'(1)) begin
            out_d   = out_q & ~armed_q;
            armed_d = '0;
         end
      end

      if (wr_en) begin
         case (address)
            AddrData: begin
               out_d   = wr_data;
               armed_d = '0;
               cnt_d   = '0;
            end
            AddrPulse: begin
               // A zero write still reloads, which extends any running strobe.
               out_d   = out_d | wr_data;
               armed_d = armed_d | wr_data;
               cnt_d   = PulseLen;
            end
            AddrSet: begin
               out_d   = out_d | wr_data;
               armed_d = armed_d & ~wr_data;
            end
            AddrClr: begin
               out_d   = out_d & ~wr_data;
               armed_d = armed_d & ~wr_data;
            end
            default: ;
         endcase
      end
   end

   // Synchroniser, edge capture and interrupt mask
   always_comb begin
      s1_d       = in_port;
      s2_d       = s1_q;
      s3_d       = s2_q;
      edge_cap_d = edge_cap_q;
      irq_mask_d = irq_mask_q;

      if (wr_en && address == AddrEdge) begin
         edge_cap_d = edge_cap_d & ~wr_data;
      end
      if (wr_en && address == AddrMask) begin
         irq_mask_d = wr_data;
      end

      // A new edge overrides a write-1-to-clear on the same bit.
      edge_cap_d = edge_cap_d | edge_cond;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q      <= OutReset;
         armed_q    <= '0;
         cnt_q      <= '0;
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         edge_cap_q <= '0;
         irq_mask_q <= '0;
      end else begin
         out_q      <= out_d;
         armed_q    <= armed_d;
         cnt_q      <= cnt_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         s3_q       <= s3_d;
         edge_cap_q <= edge_cap_d;
         irq_mask_q <= irq_mask_d;
      end
   end

   // Zero-wait read mux; unmapped and write-only addresses return zero.
   always_comb begin
      readdata = '0;
      case (address)
         AddrData:  readdata[WIDTH-1:0] = out_q;
         AddrPulse: readdata[WIDTH-1:0] = armed_q;
         AddrIn:    readdata[WIDTH-1:0] = s2_q;
         AddrEdge:  readdata[WIDTH-1:0] = edge_cap_q;
         AddrMask:  readdata[WIDTH-1:0] = irq_mask_q;
         default:   readdata = '0;
      endcase
   end

   assign out_port = out_q;
   assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio_pulse.sv
// Self-checking bench for avalon_pio_pulse (WIDTH=8, PULSE_CYCLES=16, RESET_VALUE=A5,
// rising-edge capture). A reference model tracks strobe expiry as an absolute cycle number
// and the input path as a history of values sampled at each clock edge.

module tb_avalon_pio_pulse;

   localparam int unsigned W  = 8;
   localparam int unsigned P  = 16;
   localparam logic [7:0]  RV = 8'hA5;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  in_port;
   logic [7:0]  out_port;
   logic        irq;

   avalon_pio_pulse #(
      .WIDTH       (W),
      .PULSE_CYCLES(P),
      .RESET_VALUE (32'(RV)),
      .EDGE_TYPE   (0)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .in_port   (in_port),
      .out_port  (out_port),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model
   logic [7:0] m_out, m_armed, m_edge, m_mask;
   int         m_expire;            // edge index at which armed bits drop, -1 if none
   int         cyc;                 // index of the next clock edge
   logic [7:0] hist [0:8191];       // in_port as seen at each edge

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_out    = RV;
      m_armed  = '0;
      m_edge   = '0;
      m_mask   = '0;
      m_expire = -1;
      hist[cyc-1] = '0;
      hist[cyc-2] = '0;
      hist[cyc-3] = '0;
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] a);
      case (a)
         3'd0:    return {24'h0, m_out};
         3'd1:    return {24'h0, m_armed};
         3'd2:    return {24'h0, hist[cyc-2]};   // value present two edges ago
         3'd3:    return {24'h0, m_edge};
         3'd4:    return {24'h0, m_mask};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_edge(input logic [2:0] a, input logic we, input logic [7:0] wd);
      int n;
      n = cyc;
      hist[n] = in_port;
      if (m_expire == n) begin
         m_out    = m_out & ~m_armed;
         m_armed  = '0;
         m_expire = -1;
      end
      if (we) begin
         case (a)
            3'd0: begin m_out = wd; m_armed = '0; m_expire = -1; end
            3'd1: begin m_out |= wd; m_armed |= wd; m_expire = n + P; end
            3'd3: m_edge &= ~wd;
            3'd4: m_mask = wd;
            3'd5: begin m_out |= wd; m_armed &= ~wd; end
            3'd6: begin m_out &= ~wd; m_armed &= ~wd; end
            default: ;
         endcase
      end
      // A rising edge seen at the synchroniser output two and three edges back.
      m_edge |= hist[n-2] & ~hist[n-3];
      cyc++;
   endtask

   // One bus cycle: drive, check read data, clock, check outputs.
   task automatic step(input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, output logic [31:0] rd);
      address    = a;
      chipselect = cs;
      write_n    = wn;
      writedata  = wd;
      #1;
      rd = readdata;
      chk("readdata", readdata, m_read(a));
      @(posedge clk);
      model_edge(a, cs & ~wn, wd[7:0]);
      #1;
      chk("out_port", {24'h0, out_port}, {24'h0, m_out});
      chk("irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
   endtask

   task automatic idle(input int n);
      logic [31:0] rd;
      for (int i = 0; i < n; i++) step(3'd0, 1'b0, 1'b1, 32'h0, rd);
   endtask

   typedef struct {
      logic [2:0]  addr;
      logic        wr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
   } vec_t;

   vec_t tbl [12];

   initial begin
      logic [31:0] rd;

      tbl[0]  = '{3'd0, 1'b0, 32'h0,        32'hA5, 8'hA5};
      tbl[1]  = '{3'd4, 1'b1, 32'h0F,       32'h00, 8'hA5};
      tbl[2]  = '{3'd4, 1'b0, 32'h0,        32'h0F, 8'hA5};
      tbl[3]  = '{3'd5, 1'b1, 32'h40,       32'h00, 8'hE5};
      tbl[4]  = '{3'd6, 1'b1, 32'h81,       32'h00, 8'h64};
      tbl[5]  = '{3'd0, 1'b1, 32'h3C,       32'h64, 8'h3C};
      tbl[6]  = '{3'd7, 1'b0, 32'h0,        32'h00, 8'h3C};
      tbl[7]  = '{3'd0, 1'b1, 32'hFFFFFF11, 32'h3C, 8'h11};
      tbl[8]  = '{3'd2, 1'b0, 32'h0,        32'h00, 8'h11};
      tbl[9]  = '{3'd0, 1'b1, 32'hA0,       32'h11, 8'hA0};
      tbl[10] = '{3'd4, 1'b1, 32'h00,       32'h0F, 8'hA0};
      tbl[11] = '{3'd3, 1'b0, 32'h0,        32'h00, 8'hA0};

      for (int i = 0; i < 8192; i++) hist[i] = '0;
      cyc        = 3;
      reset      = 1'b1;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      in_port    = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out", {24'h0, out_port}, 32'hA5);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      reset = 1'b0;
      model_reset();

      // Reset state of every register
      for (int a = 0; a < 8; a++) step(3'(a), 1'b0, 1'b1, 32'h0, rd);

      // Register map vectors
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].addr, tbl[i].wr, ~tbl[i].wr, tbl[i].wd, rd);
         chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
         chk($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, tbl[i].exp_out});
      end

      // Strobe of bits 0 and 2 from a background of A0 lasts exactly P cycles
      step(3'd1, 1'b1, 1'b0, 32'h05, rd);
      chk("pulse_on", {24'h0, out_port}, 32'hA5);
      for (int k = 1; k < 16; k++) begin
         step(3'd0, 1'b0, 1'b1, 32'h0, rd);
         chk("pulse_hold", {24'h0, out_port}, 32'hA5);
      end
      step(3'd0, 1'b0, 1'b1, 32'h0, rd);
      chk("pulse_expire", {24'h0, out_port}, 32'hA0);
      step(3'd1, 1'b0, 1'b1, 32'h0, rd);
      chk("pulse_armed_rd", rd, 32'h0);

      // Retrigger: both bits share the later expiry; SET takes bit 0 out of the strobe
      step(3'd1, 1'b1, 1'b0, 32'h01, rd);           // t
      idle(4);
      step(3'd5, 1'b1, 1'b0, 32'h01, rd);           // t+5
      idle(4);
      step(3'd1, 1'b1, 1'b0, 32'h02, rd);           // t+10
      chk("retrig_on", {24'h0, out_port}, 32'hA3);
      for (int k = 0; k < 15; k++) begin
         step(3'd0, 1'b0, 1'b1, 32'h0, rd);
         chk("retrig_hold", {24'h0, out_port}, 32'hA3);
      end
      step(3'd0, 1'b0, 1'b1, 32'h0, rd);            // t+26
      chk("retrig_expire", {24'h0, out_port}, 32'hA1);

      // Edge capture latency and interrupt
      step(3'd4, 1'b1, 1'b0, 32'h08, rd);
      in_port = 8'h08;
      step(3'd2, 1'b0, 1'b1, 32'h0, rd);            // edge k
      chk("edge_irq_k", {31'h0, irq}, 32'h0);
      step(3'd2, 1'b0, 1'b1, 32'h0, rd);            // edge k+1
      chk("in_before", rd, 32'h0);
      chk("edge_irq_k1", {31'h0, irq}, 32'h0);
      step(3'd2, 1'b0, 1'b1, 32'h0, rd);            // edge k+2
      chk("in_after", rd, 32'h08);
      chk("edge_irq_k2", {31'h0, irq}, 32'h1);
      step(3'd3, 1'b1, 1'b0, 32'h08, rd);
      chk("edge_rd", rd, 32'h08);
      chk("edge_clr_irq", {31'h0, irq}, 32'h0);

      // Clear in the same cycle as a new edge: the edge wins
      in_port = 8'h00;
      idle(4);
      in_port = 8'h08;
      idle(2);
      step(3'd3, 1'b1, 1'b0, 32'h08, rd);
      chk("set_wins_irq", {31'h0, irq}, 32'h1);
      step(3'd3, 1'b0, 1'b1, 32'h0, rd);
      chk("set_wins_rd", rd, 32'h08);

      // Glitch shorter than a clock between edges is never captured
      in_port = 8'h00;
      idle(4);
      step(3'd3, 1'b1, 1'b0, 32'hFF, rd);
      #2 in_port = 8'h08;
      #3 in_port = 8'h00;
      idle(4);
      step(3'd3, 1'b0, 1'b1, 32'h0, rd);
      chk("glitch_rd", rd, 32'h0);
      chk("glitch_irq", {31'h0, irq}, 32'h0);

      // Reset part-way through a strobe
      step(3'd1, 1'b1, 1'b0, 32'h02, rd);
      idle(4);
      address    = 3'd1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      #2 reset = 1'b1;
      #1;
      chk("midreset_out", {24'h0, out_port}, 32'hA5);
      chk("midreset_armed", readdata, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      step(3'd5, 1'b1, 1'b0, 32'h02, rd);
      idle(20);
      chk("post_reset_set", {24'h0, out_port}, 32'hA7);

      // Randomised traffic against the model
      for (int i = 0; i < 800; i++) begin
         logic [2:0]  a;
         logic        cs, wn;
         logic [31:0] wd;
         a  = 3'($urandom_range(0, 7));
         cs = 1'($urandom_range(0, 1));
         wn = ($urandom_range(0, 2) == 0);
         wd = $urandom;
         if (a == 3'd0 && $urandom_range(0, 3) != 0) wn = 1'b1;   // keep strobes alive longer
         if ($urandom_range(0, 4) == 0) in_port = 8'($urandom);
         step(a, cs, wn, wd, rd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
